subckt_vector_sequencer: RTL and testbench

- Test-pattern controller for one 5-input, 1-output sequential netlist subcircuit used in trojan-detection experiments.
- Accepts stimulus vectors and their golden expected outputs through a valid/ready stream, and drives the subcircuit inputs.
- Aligns each expected bit with the subcircuit's register latency, compares it against the actual output, and reports mismatch statistics at the end of a run.
- Sits between the pattern source/golden-model feeder and the subcircuit instance under test.

---
 rtl/subckt_seq_pkg.sv | 38 +++
 rtl/subckt_exp_pipe.sv | 43 ++++
 rtl/subckt_vector_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_subckt_vector_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/subckt_seq_pkg.sv
// Shared types and constants for the subcircuit vector sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package subckt_seq_pkg;

    localparam int N_IN_DEF    = 5;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    // Width of the vector index carried in each expectation tag.
    localparam int TAG_IDX_W = CNT_W_DEF;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // One expectation travelling alongside the subcircuit's register latency.
    typedef struct packed {
        logic                 valid;
        logic                 exp;
        logic [TAG_IDX_W-1:0] idx;
    } exp_tag_t;

    // One MISR step for x^16+x^12+x^5+1: shift left, fold feedback into the taps.
    function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic din);
        logic fb;
        fb = cur[15] ^ din;
        return {cur[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/subckt_exp_pipe.sv
// Expectation tag delay line: DEPTH-stage shift register of exp_tag_t.
// Latency: tag_i appears on tag_o DEPTH edges after it is loaded.
// Backpressure: none; shifts every cycle, clr_i empties all stages.
module subckt_exp_pipe
    import subckt_seq_pkg::*;
#(
    parameter int DEPTH = LATENCY_DEF + 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clr_i,
    input  exp_tag_t tag_i,
    output exp_tag_t tag_o,
    output logic     any_valid_o
);

    exp_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset and clear both flush every stage.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Any outstanding expectation keeps the sequencer in DRAIN.
    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid_o = any_valid_o | stage_q[i].valid;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/subckt_vector_sequencer.sv
// Drives stimulus vectors into a sequential subcircuit and checks its output against golden bits.
// Latency: vector accepted at edge k is compared with dut_out at edge k+LATENCY+1.
// Backpressure: vec_ready only in RUN while vectors remain; optional MISR via SUBCKT_SEQ_MISR_EN.
module subckt_vector_sequencer
    import subckt_seq_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N_IN-1:0]  vec_data,
    input  logic             vec_exp,
    output logic [N_IN-1:0]  dut_in,
    output logic             dut_rst,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [15:0]      sig
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [N_IN-1:0]  dut_in_q, dut_in_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;

    exp_tag_t tag_in;
    exp_tag_t tag_out;
    logic     pipe_clr;
    logic     pipe_any_valid;
    logic     cmp_vld;
    logic     mismatch;

    // The tag pipe is one stage deeper than the subcircuit because dut_in is itself registered.
    subckt_exp_pipe #(
        .DEPTH (LATENCY + 1)
    ) u_exp_pipe (
        .clk_i       (I1470_clk),
        .rst_i       (I1477_rst),
        .clr_i       (pipe_clr),
        .tag_i       (tag_in),
        .tag_o       (tag_out),
        .any_valid_o (pipe_any_valid)
    );

    assign cmp_vld  = tag_out.valid;
    assign mismatch = cmp_vld && (dut_out != tag_out.exp);

    // Next-state, handshake and result bookkeeping; start in IDLE overrides stale results.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        issued_d  = issued_q;
        dut_in_d  = dut_in_q;
        fail_d    = fail_q;
        mm_cnt_d  = mm_cnt_q;
        ffi_d     = ffi_q;
        tag_in    = '0;
        pipe_clr  = 1'b0;
        vec_ready = 1'b0;
        dut_rst   = 1'b0;
        done      = 1'b0;

        if (mismatch) begin
            if (mm_cnt_q != {CNT_W{1'b1}}) begin
                mm_cnt_d = mm_cnt_q + CNT_W'(1);
            end
            if (!fail_q) begin
                fail_d = 1'b1;
                ffi_d  = CNT_W'(tag_out.idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_INIT;
                    num_d    = num_vec;
                    issued_d = '0;
                    dut_in_d = '0;
                    fail_d   = 1'b0;
                    mm_cnt_d = '0;
                    ffi_d    = '0;
                    pipe_clr = 1'b1;
                end
            end
            ST_INIT: begin
                dut_rst = 1'b1;
                state_d = (num_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                // issued never exceeds num, so inequality means vectors remain.
                vec_ready = (issued_q != num_q);
                if (vec_valid && vec_ready) begin
                    dut_in_d     = vec_data;
                    issued_d     = issued_q + CNT_W'(1);
                    tag_in.valid = 1'b1;
                    tag_in.exp   = vec_exp;
                    tag_in.idx   = TAG_IDX_W'(issued_q);
                end
                if (issued_d == num_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_any_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers; reset aborts any run without a done pulse.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            issued_q <= '0;
            dut_in_q <= '0;
            fail_q   <= 1'b0;
            mm_cnt_q <= '0;
            ffi_q    <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            dut_in_q <= dut_in_d;
            fail_q   <= fail_d;
            mm_cnt_q <= mm_cnt_d;
            ffi_q    <= ffi_d;
        end
    end

`ifdef SUBCKT_SEQ_MISR_EN
    logic [15:0] sig_q, sig_d;

    // MISR is seeded in INIT and only advances on edges that perform a compare.
    always_comb begin
        sig_d = sig_q;
        if (state_q == ST_INIT) begin
            sig_d = MISR_SEED;
        end else if (cmp_vld) begin
            sig_d = misr_step(sig_q, dut_out);
        end
    end

    // Signature register; holds after DONE since no compares occur outside a run.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 16'h0000;
`endif

    assign dut_in         = dut_in_q;
    assign busy           = (state_q != ST_IDLE);
    assign fail           = fail_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_subckt_vector_sequencer.sv
// Randomized bench for subckt_vector_sequencer with a 2-flop parity subcircuit model.
// Latency: checks done timing relative to the last accepted vector.
// Backpressure: exercises constant, toggling and random vec_valid.
module tb_subckt_vector_sequencer;

    localparam int N_IN  = 5;
    localparam int LAT   = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             vec_valid;
    logic             vec_ready;
    logic [N_IN-1:0]  vec_data;
    logic             vec_exp;
    logic [N_IN-1:0]  dut_in;
    logic             dut_rst;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [15:0]      sig;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subckt_vector_sequencer #(
        .N_IN    (N_IN),
        .LATENCY (LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .I1470_clk      (clk),
        .I1477_rst      (rst),
        .start          (start),
        .num_vec        (num_vec),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_data       (vec_data),
        .vec_exp        (vec_exp),
        .dut_in         (dut_in),
        .dut_rst        (dut_rst),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .sig            (sig)
    );

    // Subcircuit under test: parity of inputs through two flops.
    logic s1_q = 1'b0;
    logic s2_q = 1'b0;
    bit   force_zero = 1'b0;

    always @(posedge clk) begin
        if (dut_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= ^dut_in;
            s2_q <= s1_q;
        end
    end

    assign dut_out = force_zero ? 1'b0 : s2_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference signature: polynomial division of the observed bit stream, seed 0xFFFF.
    function automatic int misr_model(input bit bits[$]);
        int s;
        s = 'hFFFF;
        foreach (bits[i]) begin
            if ((((s >> 15) & 1) ^ int'(bits[i])) != 0) s = ((s << 1) ^ 'h1021) & 'hFFFF;
            else                                       s = (s << 1) & 'hFFFF;
        end
        return s;
    endfunction

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_fail"}, fail, 0);
        check_eq({tag, "_mm"}, mismatch_cnt, 0);
        check_eq({tag, "_ffi"}, first_fail_idx, 0);
        check_eq({tag, "_sig"}, sig, 0);
        check_eq({tag, "_din"}, dut_in, 0);
        check_eq({tag, "_drst"}, dut_rst, 0);
        check_eq({tag, "_rdy"}, vec_ready, 0);
    endtask

    // One run: vmode 0=always valid, 1=toggle, 2=random. faults[i] inverts golden bit of vector i.
    task automatic run_seq(input int n, input int vmode, input logic [31:0] faults, input int abort_after);
        logic [N_IN-1:0] exp_din;
        int hs_cnt, rdy_cnt, rst_cnt, late_rdy, din_err, cyc, budget, done_cyc, last_hs;
        int mm, ffi, exp_done;
        bit got_done, tog;
        bit bits[$];

        exp_din = '0; hs_cnt = 0; rdy_cnt = 0; rst_cnt = 0; late_rdy = 0; din_err = 0;
        done_cyc = 0; last_hs = 0; got_done = 0; tog = 0;
        budget = 8 * n + 40;

        @(negedge clk);
        num_vec = CNT_W'(n); start = 1'b1; vec_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check_eq("init_drst", dut_rst, 1);
        check_eq("init_din", dut_in, 0);
        check_eq("init_rdy", vec_ready, 0);

        while (cyc <= budget) begin
            if (dut_rst) rst_cnt++;
            if (dut_in !== exp_din) din_err++;
            if (done) begin
                got_done = 1; done_cyc = cyc;
                break;
            end
            if (abort_after > 0 && hs_cnt == abort_after) break;

            // A start while busy must be ignored.
            start   = (cyc == 3);
            num_vec = (cyc == 3) ? CNT_W'(7) : CNT_W'(n);
            case (vmode)
                0:       vec_valid = 1'b1;
                1:       begin vec_valid = ~tog; tog = ~tog; end
                default: vec_valid = 1'($urandom_range(0, 1));
            endcase
            vec_data = N_IN'($urandom);
            vec_exp  = (force_zero ? 1'b0 : ^vec_data) ^ ((hs_cnt < 32) ? faults[hs_cnt] : 1'b0);
            if (vec_ready) begin
                rdy_cnt++;
                if (hs_cnt >= n) late_rdy++;
            end
            if (vec_valid && vec_ready) begin
                exp_din = vec_data;
                bits.push_back(force_zero ? 1'b0 : ^vec_data);
                hs_cnt++;
                last_hs = cyc;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; vec_valid = 1'b0;

        if (abort_after > 0) begin
            check_eq("abort_reached", hs_cnt, abort_after);
            check_eq("abort_no_done", got_done, 0);
            rst = 1'b1;
            @(negedge clk);
            check_idle_reset("midrst");
            rst = 1'b0;
            repeat (2) @(negedge clk);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
        end else begin
            mm = 0; ffi = -1;
            for (int i = 0; i < n; i++) begin
                if (faults[i]) begin
                    mm++;
                    if (ffi < 0) ffi = i;
                end
            end
            if (ffi < 0) ffi = 0;
            exp_done = (n == 0) ? 3 : last_hs + LAT + 3;
            check_eq("done_seen", got_done, 1);
            check_eq("done_cycle", done_cyc, exp_done);
            check_eq("accepted", hs_cnt, n);
            check_eq("late_ready", late_rdy, 0);
            if (vmode == 0) check_eq("ready_cycles", rdy_cnt, n);
            check_eq("drst_pulses", rst_cnt, 1);
            check_eq("din_track", din_err, 0);
            check_eq("fail", fail, (mm > 0) ? 1 : 0);
            check_eq("mismatch_cnt", mismatch_cnt, mm);
            check_eq("first_fail_idx", first_fail_idx, ffi);
`ifdef SUBCKT_SEQ_MISR_EN
            check_eq("sig", sig, misr_model(bits));
`else
            check_eq("sig_zero", sig, 0);
`endif
            @(negedge clk);
            check_eq("done_1cyc", done, 0);
            check_eq("idle_busy", busy, 0);
            repeat (3) @(negedge clk);
            check_eq("hold_mm", mismatch_cnt, mm);
            check_eq("hold_fail", fail, (mm > 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0;
        vec_valid = 1'b0; vec_data = '0; vec_exp = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;

        run_seq(8, 0, 32'h0, 0);
        run_seq(10, 0, 32'h48, 0);
        run_seq(4, 1, 32'h0, 0);
        run_seq(4, 1, 32'hF, 0);
        run_seq(0, 0, 32'h0, 0);
        run_seq(1, 0, 32'h1, 0);
        run_seq(20, 0, 32'h1F, 5);
        run_seq(6, 0, 32'h0, 0);
        force_zero = 1'b1;
        run_seq(8, 0, 32'h0, 0);
        force_zero = 1'b0;
        repeat (8) begin
            run_seq($urandom_range(1, 16), $urandom_range(0, 2), $urandom, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
